// File: rtl/regfile_psr_pkg.sv
// Shared CPU definitions: PSR flag bit positions and branch condition-code encodings.
// Used by the register file, the ALU and the instruction decoder.
package regfile_psr_pkg;

    localparam int unsigned NUM_REGS  = 16;
    localparam int unsigned REG_AW    = 4;
    localparam int unsigned NUM_FLAGS = 5;

    // PSR / CLFZN bit positions
    localparam int unsigned FLAG_C = 4;
    localparam int unsigned FLAG_L = 3;
    localparam int unsigned FLAG_F = 2;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_N = 0;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_HI = 4'b0100,
        COND_LS = 4'b0101,
        COND_GT = 4'b0110,
        COND_LE = 4'b0111,
        COND_FS = 4'b1000,
        COND_FC = 4'b1001,
        COND_LO = 4'b1010,
        COND_HS = 4'b1011,
        COND_LT = 4'b1100,
        COND_GE = 4'b1101,
        COND_UC = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

endpackage

// File: rtl/regfile_psr_cond_eval.sv
// Branch/jump condition evaluator: decodes a 4-bit condition code against the stored flags.
module cond_eval
    import regfile_psr_pkg::*;
(
    input  logic [NUM_FLAGS-1:0] psr,
    input  logic [3:0]           cond,
    output logic                 cond_true
);

    logic f_c, f_l, f_f, f_z, f_n;

    always_comb begin
        f_c = psr[FLAG_C];
        f_l = psr[FLAG_L];
        f_f = psr[FLAG_F];
        f_z = psr[FLAG_Z];
        f_n = psr[FLAG_N];
    end

    always_comb begin
        cond_true = 1'b0;
        case (cond_e'(cond))
            COND_EQ: cond_true = f_z;
            COND_NE: cond_true = !f_z;
            COND_CS: cond_true = f_c;
            COND_CC: cond_true = !f_c;
            COND_HI: cond_true = f_l;
            COND_LS: cond_true = !f_l;
            COND_GT: cond_true = f_n;
            COND_LE: cond_true = !f_n;
            COND_FS: cond_true = f_f;
            COND_FC: cond_true = !f_f;
            COND_LO: cond_true = !f_l && !f_z;
            COND_HS: cond_true = f_l || f_z;
            COND_LT: cond_true = !f_n && !f_z;
            COND_GE: cond_true = f_n || f_z;
            COND_UC: cond_true = 1'b1;
            COND_NV: cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/regfile_psr.sv
// 16 x DATA_W register file with two combinational read ports, optional write forwarding,
// and the processor status register feeding the condition evaluator.
module regfile_psr
    import regfile_psr_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter bit          BYPASS = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [REG_AW-1:0]    ra_addr,
    input  logic [REG_AW-1:0]    rb_addr,
    output logic [DATA_W-1:0]    A,
    output logic [DATA_W-1:0]    B,
    input  logic                 hold,
    input  logic                 wr_en,
    input  logic [REG_AW-1:0]    wr_addr,
    input  logic [DATA_W-1:0]    S,
    input  logic                 flag_en,
    input  logic [NUM_FLAGS-1:0] CLFZN,
    output logic [NUM_FLAGS-1:0] psr,
    input  logic [3:0]           cond,
    output logic                 cond_true
);

    logic [DATA_W-1:0]    regs_q [NUM_REGS];
    logic [DATA_W-1:0]    regs_d [NUM_REGS];
    logic [NUM_FLAGS-1:0] psr_q;
    logic [NUM_FLAGS-1:0] psr_d;
    logic                 wr_live;
    logic                 fwd_a;
    logic                 fwd_b;

    always_comb begin
        regs_d  = regs_q;
        psr_d   = psr_q;
        wr_live = !hold && wr_en;
        if (wr_live) begin
            regs_d[wr_addr] = S;
        end
        if (!hold && flag_en) begin
            psr_d = CLFZN;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs_q <= '{default: '0};
            psr_q  <= '0;
        end else begin
            regs_q <= regs_d;
            psr_q  <= psr_d;
        end
    end

    // Forwarding only for a write that will actually commit this edge.
    always_comb begin
        fwd_a = BYPASS && wr_live && (ra_addr == wr_addr);
        fwd_b = BYPASS && wr_live && (rb_addr == wr_addr);
        A     = fwd_a ? S : regs_q[ra_addr];
        B     = fwd_b ? S : regs_q[rb_addr];
        psr   = psr_q;
    end

    // Conditions look at the stored flags only, never the incoming CLFZN.
    cond_eval u_cond_eval (
        .psr       (psr_q),
        .cond      (cond),
        .cond_true (cond_true)
    );

endmodule
